// File: rtl/interval_timer_ctrl.sv
// Programmable interval timer: prescaled up-counter sequenced through IDLE/RUN/DONE,
// with one-shot or auto-reload operation and single-cycle tick/err pulses.
module interval_timer_ctrl #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  mode_reload,
    input  logic [WIDTH-1:0]      period,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [WIDTH-1:0]      count,
    output logic                  busy,
    output logic                  done,
    output logic                  tick,
    output logic                  err,
    output logic [1:0]            state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [WIDTH-1:0]      count_d;
    logic [PRESCALE_W-1:0] pre_q, pre_d;
    logic [WIDTH-1:0]      period_q, period_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic                  reload_q, reload_d;
    logic                  tick_d, err_d;

    // State and datapath registers; busy/done are registered from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            count      <= '0;
            pre_q      <= '0;
            period_q   <= '0;
            prescale_q <= '0;
            reload_q   <= 1'b0;
            tick       <= 1'b0;
            err        <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_d;
            count      <= count_d;
            pre_q      <= pre_d;
            period_q   <= period_d;
            prescale_q <= prescale_d;
            reload_q   <= reload_d;
            tick       <= tick_d;
            err        <= err_d;
            busy       <= (state_d == ST_RUN);
            done       <= (state_d == ST_DONE);
        end
    end

    assign state = state_q;

    // Next-state and datapath: stop beats start, start only accepted outside RUN.
    always_comb begin
        state_d    = state_q;
        count_d    = count;
        pre_d      = pre_q;
        period_d   = period_q;
        prescale_d = prescale_q;
        reload_d   = reload_q;
        tick_d     = 1'b0;
        err_d      = 1'b0;

        if (stop) begin
            state_d = ST_IDLE;
            count_d = '0;
            pre_d   = '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (pre_q == prescale_q) begin
                        pre_d = '0;
                        if (count == period_q) begin
                            count_d = '0;
                            tick_d  = 1'b1;
                            if (!reload_q) begin
                                state_d = ST_DONE;
                            end
                        end else begin
                            count_d = count + WIDTH'(1);
                        end
                    end else begin
                        pre_d = pre_q + PRESCALE_W'(1);
                    end
                end
                default: begin
                    // IDLE, DONE and the unused encoding share the start handling;
                    // the unused encoding falls back to IDLE.
                    if (state_q != ST_DONE) begin
                        state_d = ST_IDLE;
                    end
                    if (start) begin
                        if (period != '0) begin
                            state_d    = ST_RUN;
                            count_d    = '0;
                            pre_d      = '0;
                            period_d   = period;
                            prescale_d = prescale;
                            reload_d   = mode_reload;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule
